// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS controller:
// FSM states, instruction classes, opcode/funct and ALU encodings.
package ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXECUTE,
    MEM,
    WB,
    FAULT
  } state_t;

  typedef enum logic [2:0] {
    C_RTYPE,
    C_LW,
    C_SW,
    C_BEQ,
    C_ADDI,
    C_ORI,
    C_J,
    C_ILL
  } iclass_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_SLT = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b101;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b111;

  function automatic logic uses_imm(iclass_t c);
    return (c == C_LW) || (c == C_SW) ||
           (c == C_ADDI) || (c == C_ORI);
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction classifier.
// Ports: instr in; cls, alucontrol, illegal, uses_rd out.
module instr_decoder
  import ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output iclass_t     cls,
  output logic [2:0]  alucontrol,
  output logic        illegal,
  output logic        uses_rd
);

  logic [5:0] op;
  logic [5:0] fn;
  logic [2:0] r_alu;
  logic       r_ok;
  logic       unused_f;

  assign op = instr[31:26];
  assign fn = instr[5:0];
  assign unused_f = ^instr[25:6];

  always_comb begin
    r_alu = ALU_ADD;
    r_ok  = 1'b1;
    unique case (1'b1)
      fn == FN_ADD: r_alu = ALU_ADD;
      fn == FN_SUB: r_alu = ALU_SUB;
      fn == FN_AND: r_alu = ALU_AND;
      fn == FN_OR:  r_alu = ALU_OR;
      fn == FN_SLT: r_alu = ALU_SLT;
      default:      r_ok  = 1'b0;
    endcase
  end

  always_comb begin
    cls        = C_ILL;
    alucontrol = ALU_ADD;
    unique case (1'b1)
      op == OP_RTYPE: begin
        if (r_ok) begin
          cls        = C_RTYPE;
          alucontrol = r_alu;
        end
      end
      op == OP_LW:   cls = C_LW;
      op == OP_SW:   cls = C_SW;
      op == OP_BEQ: begin
        cls        = C_BEQ;
        alucontrol = ALU_SUB;
      end
      op == OP_ADDI: cls = C_ADDI;
      op == OP_ORI: begin
        cls        = C_ORI;
        alucontrol = ALU_OR;
      end
      op == OP_J:    cls = C_J;
      default:       cls = C_ILL;
    endcase
  end

  assign illegal = (cls == C_ILL);
  assign uses_rd = (cls == C_RTYPE);

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS sequencer: FSM, memory wait timeout, retire count.
// Ports: clk, reset(n), instr, imem/dmem req/ack, zero in; datapath controls, fault, retired out.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int RET_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic             imem_ack,
  output logic             imem_req,
  output logic             irwrite,
  input  logic             dmem_ack,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             zero,
  output logic             pcen,
  output logic             regwrite,
  output logic             memtoreg,
  output logic             alusrcbimm,
  output logic [4:0]       destreg,
  output logic             dobranch,
  output logic             jump,
  output logic [2:0]       alucontrol,
  output logic             fault,
  output logic [RET_W-1:0] retired
);

  state_t     state;
  state_t     state_n;
  logic       run;
  logic [15:0] wcnt;
  logic [15:0] wcnt_n;
  logic       expired;
  iclass_t    cls;
  logic [2:0] alu;
  logic       illegal;
  logic       uses_rd;
  logic       imm;
  logic [4:0] rt;
  logic [4:0] rd;
  logic       unused_i;

  instr_decoder u_dec (
    .instr      (instr),
    .cls        (cls),
    .alucontrol (alu),
    .illegal    (illegal),
    .uses_rd    (uses_rd)
  );

  assign rt  = instr[20:16];
  assign rd  = instr[15:11];
  assign imm = uses_imm(cls);
  assign unused_i = ^{instr[31:21], instr[10:0]};

  // Last allowed wait cycle; an ack in this cycle still wins.
  assign expired = (wcnt == 16'(MEM_TIMEOUT - 1));

  // run holds outputs quiet until the first edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= FETCH;
      run     <= 1'b0;
      wcnt    <= '0;
      retired <= '0;
    end else begin
      run   <= 1'b1;
      state <= state_n;
      wcnt  <= wcnt_n;
      if (pcen)
        retired <= retired + RET_W'(1);
    end
  end

  always_comb begin
    state_n    = state;
    wcnt_n     = '0;
    imem_req   = 1'b0;
    irwrite    = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    pcen       = 1'b0;
    regwrite   = 1'b0;
    memtoreg   = 1'b0;
    alusrcbimm = 1'b0;
    destreg    = '0;
    dobranch   = 1'b0;
    jump       = 1'b0;
    alucontrol = '0;
    fault      = 1'b0;
    if (run) begin
      unique case (state)
        FETCH: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            irwrite = 1'b1;
            state_n = DECODE;
          end else if (expired) begin
            state_n = FAULT;
          end else begin
            wcnt_n = wcnt + 16'd1;
          end
        end
        DECODE: begin
          state_n = illegal ? FAULT : EXECUTE;
        end
        EXECUTE: begin
          alucontrol = alu;
          alusrcbimm = imm;
          unique case (cls)
            C_RTYPE, C_ADDI, C_ORI:
              state_n = WB;
            C_LW, C_SW:
              state_n = MEM;
            C_BEQ: begin
              dobranch = zero;
              pcen     = 1'b1;
              state_n  = FETCH;
            end
            C_J: begin
              jump    = 1'b1;
              pcen    = 1'b1;
              state_n = FETCH;
            end
            default:
              state_n = FAULT;
          endcase
        end
        MEM: begin
          // Address operands stay driven until the access completes.
          alucontrol = alu;
          alusrcbimm = imm;
          dmem_req   = 1'b1;
          dmem_we    = (cls == C_SW);
          if (dmem_ack) begin
            pcen    = 1'b1;
            state_n = FETCH;
            if (cls == C_LW) begin
              regwrite = 1'b1;
              memtoreg = 1'b1;
              destreg  = rt;
            end
          end else if (expired) begin
            state_n = FAULT;
          end else begin
            wcnt_n = wcnt + 16'd1;
          end
        end
        WB: begin
          alucontrol = alu;
          alusrcbimm = imm;
          regwrite   = 1'b1;
          destreg    = uses_rd ? rd : rt;
          pcen       = 1'b1;
          state_n    = FETCH;
        end
        FAULT: begin
          fault = 1'b1;
        end
        default: begin
          state_n = FAULT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed table,
// corner sequences and random instructions against a timeline model.
module tb_multicycle_controller;

  localparam int TMO = 4;
  localparam int RW  = 4;

  localparam int F_IREQ = 9;
  localparam int F_IRW  = 8;
  localparam int F_DREQ = 7;
  localparam int F_DWE  = 6;
  localparam int F_PCEN = 5;
  localparam int F_RW   = 4;
  localparam int F_MTR  = 3;
  localparam int F_BR   = 2;
  localparam int F_J    = 1;
  localparam int F_FLT  = 0;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   instr = '0;
  logic          imem_ack = 1'b0;
  logic          dmem_ack = 1'b0;
  logic          zero = 1'b0;
  logic          imem_req, irwrite, dmem_req, dmem_we;
  logic          pcen, regwrite, memtoreg, alusrcbimm;
  logic [4:0]    destreg;
  logic          dobranch, jump, fault;
  logic [2:0]    alucontrol;
  logic [RW-1:0] retired;
  logic [9:0]    gflags;

  multicycle_controller #(
    .MEM_TIMEOUT (TMO),
    .RET_W       (RW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .instr      (instr),
    .imem_ack   (imem_ack),
    .imem_req   (imem_req),
    .irwrite    (irwrite),
    .dmem_ack   (dmem_ack),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .zero       (zero),
    .pcen       (pcen),
    .regwrite   (regwrite),
    .memtoreg   (memtoreg),
    .alusrcbimm (alusrcbimm),
    .destreg    (destreg),
    .dobranch   (dobranch),
    .jump       (jump),
    .alucontrol (alucontrol),
    .fault      (fault),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  assign gflags = {imem_req, irwrite, dmem_req, dmem_we, pcen,
                   regwrite, memtoreg, dobranch, jump, fault};

  typedef struct {
    logic       ia;
    logic       da;
    logic       z;
    logic [9:0] f;
    logic       crd;
    logic [4:0] rd;
    logic       calu;
    logic [2:0] alu;
    logic       bimm;
  } cyc_t;

  typedef struct {
    logic [31:0] ins;
    int          df;
    int          dm;
    logic        z;
    int          lat;
    logic        flt;
  } vec_t;

  cyc_t          q[$];
  vec_t          tbl[$];
  logic [31:0]   cur;
  logic [RW-1:0] mret;
  int            nerr = 0;
  int            nchk = 0;
  int            jcnt = 0;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, got, exp, $time);
    end
  endtask

  // Instruction kinds: 0 R, 1 lw, 2 sw, 3 beq, 4 addi, 5 ori, 6 j, 7 illegal
  function automatic int kind_of(logic [31:0] ins);
    case (ins[31:26])
      6'b000000:
        case (ins[5:0])
          6'b100000, 6'b100010, 6'b100100,
          6'b100101, 6'b101010: return 0;
          default: return 7;
        endcase
      6'b100011: return 1;
      6'b101011: return 2;
      6'b000100: return 3;
      6'b001000: return 4;
      6'b001101: return 5;
      6'b000010: return 6;
      default:   return 7;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(logic [31:0] ins, int k);
    if (k == 0) begin
      case (ins[5:0])
        6'b100000: return 3'b101;
        6'b100010: return 3'b001;
        6'b100100: return 3'b111;
        6'b100101: return 3'b110;
        default:   return 3'b000;
      endcase
    end
    if (k == 3) return 3'b001;
    if (k == 5) return 3'b110;
    return 3'b101;
  endfunction

  // Idle cycle: acks/zero random because they must be ignored here.
  function automatic cyc_t blank();
    cyc_t c;
    c.ia   = 1'($urandom_range(0, 1));
    c.da   = 1'($urandom_range(0, 1));
    c.z    = 1'($urandom_range(0, 1));
    c.f    = '0;
    c.crd  = 1'b0;
    c.rd   = '0;
    c.calu = 1'b0;
    c.alu  = '0;
    c.bimm = 1'b0;
    return c;
  endfunction

  task automatic push_fault();
    cyc_t c;
    for (int i = 0; i < 3; i++) begin
      c = blank();
      c.f[F_FLT] = 1'b1;
      c.crd  = 1'b1;
      c.calu = 1'b1;
      q.push_back(c);
    end
  endtask

  // Builds the expected per-cycle timeline of one instruction.
  task automatic gen(input logic [31:0] ins, input int df,
                     input int dm, input logic z);
    cyc_t c;
    int   k;
    int   nw;
    k   = kind_of(ins);
    cur = ins;
    q.delete();
    nw = (df < TMO) ? df : TMO;
    for (int i = 0; i < nw; i++) begin
      c = blank();
      c.ia = 1'b0;
      c.f[F_IREQ] = 1'b1;
      q.push_back(c);
    end
    if (df >= TMO) begin
      push_fault();
      return;
    end
    c = blank();
    c.ia = 1'b1;
    c.f[F_IREQ] = 1'b1;
    c.f[F_IRW]  = 1'b1;
    q.push_back(c);
    q.push_back(blank());
    if (k == 7) begin
      push_fault();
      return;
    end
    c = blank();
    c.calu = (k != 6);
    c.alu  = alu_of(ins, k);
    c.bimm = (k == 1) || (k == 2) || (k == 4) || (k == 5);
    if (k == 3) begin
      c.z = z;
      c.f[F_PCEN] = 1'b1;
      c.f[F_BR]   = z;
      q.push_back(c);
      return;
    end
    if (k == 6) begin
      c.f[F_PCEN] = 1'b1;
      c.f[F_J]    = 1'b1;
      q.push_back(c);
      return;
    end
    q.push_back(c);
    if (k == 0 || k == 4 || k == 5) begin
      c = blank();
      c.f[F_RW]   = 1'b1;
      c.f[F_PCEN] = 1'b1;
      c.crd = 1'b1;
      c.rd  = (k == 0) ? ins[15:11] : ins[20:16];
      q.push_back(c);
      return;
    end
    nw = (dm < TMO) ? dm : TMO;
    for (int i = 0; i < nw; i++) begin
      c = blank();
      c.da = 1'b0;
      c.f[F_DREQ] = 1'b1;
      c.f[F_DWE]  = (k == 2);
      q.push_back(c);
    end
    if (dm >= TMO) begin
      push_fault();
      return;
    end
    c = blank();
    c.da = 1'b1;
    c.f[F_DREQ] = 1'b1;
    c.f[F_DWE]  = (k == 2);
    c.f[F_PCEN] = 1'b1;
    if (k == 1) begin
      c.f[F_RW]  = 1'b1;
      c.f[F_MTR] = 1'b1;
      c.crd = 1'b1;
      c.rd  = ins[20:16];
    end
    q.push_back(c);
  endtask

  // Plays the first n timeline cycles (all if n<0); lat = first DUT pcen cycle.
  task automatic apply(input int n, output int lat);
    lat = -1;
    for (int i = 0; i < q.size(); i++) begin
      if (n >= 0 && i >= n) break;
      imem_ack = q[i].ia;
      dmem_ack = q[i].da;
      zero     = q[i].z;
      instr    = cur;
      #3;
      chk("flags", 64'(gflags), 64'(q[i].f));
      chk("retired", 64'(retired), 64'(mret));
      if (q[i].crd)
        chk("destreg", 64'(destreg), 64'(q[i].rd));
      if (q[i].calu) begin
        chk("alucontrol", 64'(alucontrol), 64'(q[i].alu));
        chk("alusrcbimm", 64'(alusrcbimm), 64'(q[i].bimm));
      end
      if (pcen === 1'b1 && lat < 0)
        lat = i + 1;
      if (jump === 1'b1)
        jcnt++;
      if (q[i].f[F_PCEN])
        mret = mret + 1'b1;
      @(posedge clk);
      #1;
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    imem_ack = 1'($urandom_range(0, 1));
    dmem_ack = 1'($urandom_range(0, 1));
    #2;
    chk("reset_outs",
        64'({gflags, destreg, alucontrol, alusrcbimm, retired}), 64'd0);
    @(posedge clk);
    #1;
    reset    = 1'b1;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    #3;
    chk("pre_run_req", 64'(imem_req), 64'd0);
    @(posedge clk);
    #1;
    mret = '0;
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [5:0]  fns [5] = '{6'b100000, 6'b100010, 6'b100100,
                             6'b100101, 6'b101010};
    int          k  = $urandom_range(0, 24);
    logic [4:0]  rs = 5'($urandom);
    logic [4:0]  rt = 5'($urandom);
    logic [4:0]  rd = 5'($urandom);
    logic [15:0] im = 16'($urandom);
    if (k < 8)  return {6'b000000, rs, rt, rd, 5'd0,
                        fns[$urandom_range(0, 4)]};
    if (k < 11) return {6'b100011, rs, rt, im};
    if (k < 14) return {6'b101011, rs, rt, im};
    if (k < 17) return {6'b000100, rs, rt, im};
    if (k < 19) return {6'b001000, rs, rt, im};
    if (k < 21) return {6'b001101, rs, rt, im};
    if (k < 23) return {6'b000010, 26'($urandom)};
    if (k < 24) return {6'b111111, rs, rt, im};
    return {6'b000000, rs, rt, rd, 5'd0, 6'b000000};
  endfunction

  function automatic int rnd_delay();
    if ($urandom_range(0, 9) == 0)
      return TMO + $urandom_range(0, 1);
    return $urandom_range(0, TMO - 1);
  endfunction

  initial begin
    int lat;
    logic [31:0] ins;

    tbl.push_back('{32'h00221820, 0, 0, 1'b0, 4, 1'b0});
    tbl.push_back('{32'h8C050008, 0, 3, 1'b0, 7, 1'b0});
    tbl.push_back('{32'h10000003, 0, 0, 1'b1, 3, 1'b0});
    tbl.push_back('{32'h10000003, 0, 0, 1'b0, 3, 1'b0});
    tbl.push_back('{32'hAC050004, 1, 0, 1'b0, 5, 1'b0});
    tbl.push_back('{32'h00221822, 2, 0, 1'b0, 6, 1'b0});
    tbl.push_back('{32'h00221824, 0, 0, 1'b0, 4, 1'b0});
    tbl.push_back('{32'h00221825, 0, 0, 1'b0, 4, 1'b0});
    tbl.push_back('{32'h0022182A, 0, 0, 1'b0, 4, 1'b0});
    tbl.push_back('{32'h2003FFFF, 0, 0, 1'b0, 4, 1'b0});
    tbl.push_back('{32'h34040F0F, 0, 0, 1'b0, 4, 1'b0});
    tbl.push_back('{32'h08100000, 3, 0, 1'b0, 6, 1'b0});
    tbl.push_back('{32'hFC000000, 0, 0, 1'b0, -1, 1'b1});
    tbl.push_back('{32'h00221821, 0, 0, 1'b0, -1, 1'b1});
    tbl.push_back('{32'h00221820, 4, 0, 1'b0, -1, 1'b1});
    tbl.push_back('{32'h8C050008, 0, 4, 1'b0, -1, 1'b1});

    mret = '0;
    do_reset();

    foreach (tbl[i]) begin
      gen(tbl[i].ins, tbl[i].df, tbl[i].dm, tbl[i].z);
      apply(-1, lat);
      chk("latency", 64'(lat), 64'(tbl[i].lat));
      chk("fault_end", 64'(fault), 64'(tbl[i].flt));
      if (tbl[i].flt)
        do_reset();
    end

    gen(32'h00221820, 0, 0, 1'b0);
    apply(-1, lat);
    gen(32'hAC050004, 0, 2, 1'b0);
    apply(3, lat);
    dmem_ack = 1'b0;
    #3;
    chk("mid_mem_req", 64'(dmem_req), 64'd1);
    reset = 1'b0;
    #1;
    chk("rst_drop_req", 64'(dmem_req), 64'd0);
    chk("rst_retired", 64'(retired), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #3;
    chk("pre_run_req", 64'(imem_req), 64'd0);
    @(posedge clk);
    #1;
    mret = '0;
    chk("fetch_after_rst", 64'(imem_req), 64'd1);

    jcnt = 0;
    for (int i = 0; i < 16; i++) begin
      gen(32'h08100000, 0, 0, 1'b0);
      apply(-1, lat);
    end
    chk("jump_pulses", 64'(jcnt), 64'd16);
    chk("retired_wrap", 64'(retired), 64'd0);

    for (int i = 0; i < 200; i++) begin
      ins = rnd_instr();
      gen(ins, rnd_delay(), rnd_delay(), 1'($urandom_range(0, 1)));
      apply(-1, lat);
      if (fault === 1'b1)
        do_reset();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
